stopwatch_controller: RTL and testbench

Control FSM for the tenth-second stopwatch on the Io shield. Debounces three raw pushbuttons (start/stop, lap, clear), sequences the tenth-second counter through enable/clear strobes, and selects what the seven-segment multiplexer shows: the live count or a frozen lap value. Sits between `io_button` and the counter/display pair in the top level.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/button_debouncer.sv | 55 +++++
 rtl/stopwatch_controller.sv | 157 +++++++++++++++
 tb/tb_stopwatch_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the tenth-second stopwatch control path.
// STOPWATCH_LAP_EN adds the LAP state to the state enum.
package stopwatch_pkg;

    localparam int COUNT_W   = 14;
    localparam int MAX_COUNT = 9999;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STOPPED = 2'd2
`ifdef STOPWATCH_LAP_EN
        ,ST_LAP    = 2'd3
`endif
    } sw_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Raw pushbutton to one-cycle press pulse: two-flop synchronizer, stability
// counter, and rising-edge detect on the accepted (debounced) level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // The counter only advances while the synchronized sample disagrees with
    // the accepted level; any agreeing sample restarts the stability window.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values.
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: debounced buttons in, counter strobes and display
// selection out. Define STOPWATCH_LAP_EN to build the lap/freeze feature.
module stopwatch_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_COUNT       = stopwatch_pkg::MAX_COUNT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              btn_start_stop,
    input  logic                              btn_lap,
    input  logic                              btn_clear,
    input  logic [stopwatch_pkg::COUNT_W-1:0] count_value,
    output logic                              count_enable,
    output logic                              count_clear,
    output logic [stopwatch_pkg::COUNT_W-1:0] display_value,
    output logic                              running,
    output logic                              overflow
);

    import stopwatch_pkg::*;

    sw_state_t          state_q, state_d;
    logic               overflow_q, overflow_d;
    logic               count_enable_q, count_clear_q, running_q;
    logic [COUNT_W-1:0] display_q, display_d;
    logic               run_d;
    logic               start_evt, clear_evt;
    logic               terminal;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_start_stop),
        .press_o(start_evt)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_clear),
        .press_o(clear_evt)
    );

`ifdef STOPWATCH_LAP_EN
    logic               lap_evt;
    logic [COUNT_W-1:0] lap_q, lap_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_lap),
        .press_o(lap_evt)
    );
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
`endif

    assign terminal = (count_value == COUNT_W'(MAX_COUNT));

    // Priority: clear > terminal count > start_stop > lap; losers are dropped.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
`ifdef STOPWATCH_LAP_EN
        lap_d      = lap_q;
`endif
        if (clear_evt) begin
            state_d    = ST_IDLE;
            overflow_d = 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_d      = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_evt) state_d = ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (terminal) begin
                        state_d    = ST_STOPPED;
                        overflow_d = 1'b1;
                    end else if (start_evt) begin
                        state_d = ST_STOPPED;
`ifdef STOPWATCH_LAP_EN
                    end else if (lap_evt) begin
                        state_d = ST_LAP;
                        lap_d   = count_value;
`endif
                    end
                end
`ifdef STOPWATCH_LAP_EN
                ST_LAP: begin
                    if (terminal) begin
                        state_d    = ST_STOPPED;
                        overflow_d = 1'b1;
                    end else if (start_evt) begin
                        state_d = ST_STOPPED;
                    end else if (lap_evt) begin
                        state_d = ST_RUNNING;
                    end
                end
`endif
                ST_STOPPED: begin
                    if (start_evt && !overflow_q) state_d = ST_RUNNING;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they move on the event edge.
    always_comb begin
`ifdef STOPWATCH_LAP_EN
        run_d     = (state_d == ST_RUNNING) || (state_d == ST_LAP);
        display_d = (state_d == ST_LAP) ? lap_d : count_value;
`else
        run_d     = (state_d == ST_RUNNING);
        display_d = count_value;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            overflow_q     <= 1'b0;
            count_enable_q <= 1'b0;
            count_clear_q  <= 1'b0;
            running_q      <= 1'b0;
            display_q      <= '0;
        end else begin
            state_q        <= state_d;
            overflow_q     <= overflow_d;
            count_enable_q <= run_d;
            count_clear_q  <= clear_evt;
            running_q      <= run_d;
            display_q      <= display_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q <= '0;
        end else begin
            lap_q <= lap_d;
        end
    end
`endif

    assign count_enable  = count_enable_q;
    assign count_clear   = count_clear_q;
    assign running       = running_q;
    assign overflow      = overflow_q;
    assign display_value = display_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller with DEBOUNCE_CYCLES = 4; the
// stimulus queues expected output snapshots and a negedge monitor checks them.
module tb_stopwatch_controller;
    import stopwatch_pkg::*;

`ifdef STOPWATCH_LAP_EN
    localparam bit        LAP_EN    = 1'b1;
    localparam sw_state_t LAP_STATE = ST_LAP;
`else
    localparam bit        LAP_EN    = 1'b0;
    localparam sw_state_t LAP_STATE = ST_RUNNING;
`endif

    logic               clk;
    logic               rst_n;
    logic               btn_start_stop, btn_lap, btn_clear;
    logic [COUNT_W-1:0] count_value;
    logic               count_enable, count_clear, running, overflow;
    logic [COUNT_W-1:0] display_value;

    stopwatch_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_start_stop(btn_start_stop),
        .btn_lap       (btn_lap),
        .btn_clear     (btn_clear),
        .count_value   (count_value),
        .count_enable  (count_enable),
        .count_clear   (count_clear),
        .display_value (display_value),
        .running       (running),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string              name;
        sw_state_t          st;
        logic               en;
        logic               run;
        logic               ovf;
        logic [COUNT_W-1:0] disp;
        int                 clr_cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   clr_pulses = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    // Monitor: count clear strobes, then retire every queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (count_clear) clr_pulses++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, ".state"}, int'(dut.state_q), int'(e.st));
            check({e.name, ".count_enable"}, int'(count_enable), int'(e.en));
            check({e.name, ".running"}, int'(running), int'(e.run));
            check({e.name, ".overflow"}, int'(overflow), int'(e.ovf));
            check({e.name, ".count_clear"}, int'(count_clear), 0);
            check({e.name, ".display_value"}, int'(display_value), int'(e.disp));
            if (e.clr_cnt >= 0) check({e.name, ".clear_pulses"}, clr_pulses, e.clr_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input sw_state_t st, input logic en,
                              input logic run, input logic ovf, input int disp,
                              input int clr_cnt);
        exp_t e;
        e.name    = name;
        e.st      = st;
        e.en      = en;
        e.run     = run;
        e.ovf     = ovf;
        e.disp    = COUNT_W'(disp);
        e.clr_cnt = clr_cnt;
        sb_q.push_back(e);
    endtask

    task automatic press(input logic s, input logic l, input logic c);
        btn_start_stop = s;
        btn_lap        = l;
        btn_clear      = c;
        tick(12);
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        tick(12);
    endtask

    initial begin
        int base;
        rst_n          = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        count_value    = '0;

        // Reset, idle, and a short glitch that must be filtered.
        tick(3);
        expect_out("in_reset", ST_IDLE, 0, 0, 0, 0, 0);
        tick(1);
        rst_n = 1'b1;
        tick(50);
        expect_out("idle_50", ST_IDLE, 0, 0, 0, 0, 0);
        btn_start_stop = 1'b1;
        tick(2);
        btn_start_stop = 1'b0;
        tick(12);
        expect_out("glitch_ignored", ST_IDLE, 0, 0, 0, 0, 0);

        // Bouncy start press yields exactly one event.
        btn_start_stop = 1'b1; tick(1);
        btn_start_stop = 1'b0; tick(1);
        btn_start_stop = 1'b1; tick(1);
        btn_start_stop = 1'b0; tick(1);
        btn_start_stop = 1'b1; tick(20);
        btn_start_stop = 1'b0; tick(12);
        expect_out("bounce_start", ST_RUNNING, 1, 1, 0, 0, -1);
        press(1, 0, 0);
        expect_out("second_press_stop", ST_STOPPED, 0, 0, 0, 0, -1);

        // Lap freeze while the counter advances, then release.
        press(1, 0, 0);
        count_value = 14'd123;
        tick(2);
        expect_out("run_live_123", ST_RUNNING, 1, 1, 0, 123, -1);
        press(0, 1, 0);
        for (int v = 124; v <= 130; v++) begin
            count_value = COUNT_W'(v);
            tick(1);
        end
        tick(1);
        expect_out("lap_frozen", LAP_STATE, 1, 1, 0, LAP_EN ? 123 : 130, -1);
        press(0, 1, 0);
        expect_out("lap_released", ST_RUNNING, 1, 1, 0, 130, -1);

        // Terminal count: stop on the next edge, sticky overflow, start ignored.
        count_value = 14'd9999;
        expect_out("tc_before_edge", ST_RUNNING, 1, 1, 0, 130, -1);
        tick(1);
        expect_out("tc_after_edge", ST_STOPPED, 0, 0, 1, 9999, -1);
        press(1, 0, 0);
        expect_out("start_after_ovf", ST_STOPPED, 0, 0, 1, 9999, -1);
        base = clr_pulses;
        press(0, 0, 1);
        expect_out("clear_after_ovf", ST_IDLE, 0, 0, 0, 9999, base + 1);

        // Clear and start_stop landing together: clear wins.
        count_value = 14'd5;
        press(1, 0, 0);
        expect_out("run_before_both", ST_RUNNING, 1, 1, 0, 5, -1);
        base = clr_pulses;
        press(1, 0, 1);
        expect_out("clear_beats_start", ST_IDLE, 0, 0, 0, 5, base + 1);

        // Reset during LAP returns everything to zero at once.
        count_value = 14'd200;
        press(1, 0, 0);
        press(0, 1, 0);
        count_value = 14'd210;
        tick(3);
        expect_out("before_reset", LAP_STATE, 1, 1, 0, LAP_EN ? 200 : 210, -1);
        tick(1);
        rst_n = 1'b0;
        expect_out("async_reset", ST_IDLE, 0, 0, 0, 0, -1);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        expect_out("after_reset_release", ST_IDLE, 0, 0, 0, 210, -1);

        // Lap press after reset: display tracks count unless the lap build freezes it.
        count_value = 14'd300;
        press(1, 0, 0);
        press(0, 1, 0);
        count_value = 14'd305;
        tick(2);
        expect_out("lap_after_reset", LAP_STATE, 1, 1, 0, LAP_EN ? 300 : 305, -1);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
